// File: rtl/hawk_att_lkup_engine.sv
// ATT lookup engine: hppa -> AttEntry via one-line buffer or a single-beat AXI read.
// Define HAWK_ATT_BYTESWAP_EN to byteswap each 64-bit lane of a captured line.
module hawk_att_lkup_engine #(
  parameter int          ADDR_W      = 40,
  parameter logic [63:0] ATT_START   = 64'hFFF6100000,
  parameter logic [63:0] HPPA_BASE   = 64'hFFF6400000,
  parameter int          ATT_ENTRIES = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lkup_valid_i,
  output logic              lkup_ready_o,
  input  logic [ADDR_W-13:0] lkup_hppa_i,
  input  logic              lkup_zero_blk_wr_i,
  input  logic              inval_i,
  output logic [63:0]       araddr_o,
  output logic [7:0]        arlen_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [511:0]      rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  input  logic              rlast_i,
  output logic              rready_o,
  output logic              trnsl_valid_o,
  input  logic              trnsl_ready_i,
  output logic [ADDR_W-13:0] trnsl_ppa_o,
  output logic [1:0]        trnsl_sts_o,
  output logic [7:0]        trnsl_zpd_cnt_o,
  output logic              trnsl_zpd_update_o,
  output logic              trnsl_allow_o,
  output logic              trnsl_err_o,
  output logic [1:0]        dbg_state_o
);

  localparam int PW = ADDR_W - 12;
  localparam int TW = PW - 3;
  localparam logic [PW-1:0] HPPA_PAGE = HPPA_BASE[ADDR_W-1:12];
  localparam logic [PW-1:0] ENTRY_LIM = PW'(ATT_ENTRIES);

  localparam logic [1:0] STS_DALLOC = 2'd0;
  localparam logic [1:0] STS_UNCOMP = 2'd1;
  localparam logic [1:0] STS_INCOMP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [PW-1:0] ppa;
    logic [1:0]    sts;
    logic [7:0]    zpd;
    logic          upd;
    logic          allow;
    logic          err;
  } trnsl_t;

  localparam trnsl_t TRNSL_RST = '{ppa: {PW{1'b0}}, sts: STS_DALLOC, zpd: 8'd0,
                                   upd: 1'b0, allow: 1'b0, err: 1'b0};
  localparam trnsl_t TRNSL_ERR = '{ppa: {PW{1'b0}}, sts: STS_DALLOC, zpd: 8'd0,
                                   upd: 1'b0, allow: 1'b0, err: 1'b1};

  // AttEntry layout: zpd_cnt[63:56], way[55:2] (ppa = way[ADDR_W-11:2]), sts[1:0]
  function automatic trnsl_t f_decode(input logic [63:0] ent, input logic zbw);
    trnsl_t t;
    t.ppa   = ent[PW+3:4];
    t.sts   = ent[1:0];
    t.zpd   = ent[63:56];
    t.allow = (ent[1:0] == STS_UNCOMP) || (ent[1:0] == STS_INCOMP);
    t.upd   = zbw && (ent[1:0] == STS_UNCOMP);
    t.err   = 1'b0;
    return t;
  endfunction

  function automatic logic [63:0] f_slice(input logic [511:0] line, input logic [2:0] sel);
    return line[{sel, 6'd0} +: 64];
  endfunction

  function automatic logic [511:0] f_line_in(input logic [511:0] d);
    logic [511:0] o;
`ifdef HAWK_ATT_BYTESWAP_EN
    o = {512{1'b0}};
    for (int l = 0; l < 8; l++) begin
      for (int j = 0; j < 8; j++) begin
        o[64*l+8*j +: 8] = d[64*l+8*(7-j) +: 8];
      end
    end
`else
    o = d;
`endif
    return o;
  endfunction

  state_t        r_state;
  logic          r_lkup_ready;
  logic          r_arvalid;
  logic [63:0]   r_araddr;
  logic          r_rready;
  logic          r_tvalid;
  trnsl_t        r_trnsl;
  logic          r_buf_vld;
  logic [TW-1:0] r_buf_tag;
  logic [511:0]  r_line;
  logic [TW-1:0] r_tag;
  logic [2:0]    r_sel;
  logic          r_zbw;

  logic [PW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic          w_oor;
  logic          w_hit;
  logic [511:0]  w_line;
  logic [63:0]   w_araddr;

  assign w_idx    = lkup_hppa_i - HPPA_PAGE;
  assign w_tag    = w_idx[PW-1:3];
  assign w_oor    = (lkup_hppa_i < HPPA_PAGE) || (w_idx >= ENTRY_LIM);
  // A same-cycle invalidate must turn a would-be hit into a miss.
  assign w_hit    = r_buf_vld && (r_buf_tag == w_tag) && !inval_i;
  assign w_line   = f_line_in(rdata_i);
  assign w_araddr = ATT_START + {{(64-TW-6){1'b0}}, w_tag, 6'd0};

  // Lookup FSM, line buffer and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_lkup_ready <= 1'b1;
      r_arvalid    <= 1'b0;
      r_araddr     <= 64'd0;
      r_rready     <= 1'b0;
      r_tvalid     <= 1'b0;
      r_trnsl      <= TRNSL_RST;
      r_buf_vld    <= 1'b0;
      r_buf_tag    <= {TW{1'b0}};
      r_line       <= {512{1'b0}};
      r_tag        <= {TW{1'b0}};
      r_sel        <= 3'd0;
      r_zbw        <= 1'b0;
    end else begin
      if (inval_i) begin
        r_buf_vld <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (lkup_valid_i) begin
            r_lkup_ready <= 1'b0;
            r_tag        <= w_tag;
            r_sel        <= w_idx[2:0];
            r_zbw        <= lkup_zero_blk_wr_i;
            if (w_oor) begin
              r_trnsl  <= TRNSL_ERR;
              r_tvalid <= 1'b1;
              r_state  <= S_RESP;
            end else if (w_hit) begin
              r_trnsl  <= f_decode(f_slice(r_line, w_idx[2:0]), lkup_zero_blk_wr_i);
              r_tvalid <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_araddr  <= w_araddr;
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          // Only the last beat carries the line; stray non-last beats are dropped.
          if (rvalid_i && rlast_i) begin
            r_rready <= 1'b0;
            r_line   <= w_line;
            r_tvalid <= 1'b1;
            r_state  <= S_RESP;
            if (rresp_i == 2'b00) begin
              r_buf_vld <= !inval_i;
              r_buf_tag <= r_tag;
              r_trnsl   <= f_decode(f_slice(w_line, r_sel), r_zbw);
            end else begin
              r_buf_vld <= 1'b0;
              r_trnsl   <= TRNSL_ERR;
            end
          end
        end
        S_RESP: begin
          if (trnsl_ready_i) begin
            r_tvalid     <= 1'b0;
            r_lkup_ready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_lkup_ready <= 1'b1;
          r_arvalid    <= 1'b0;
          r_rready     <= 1'b0;
          r_tvalid     <= 1'b0;
        end
      endcase
    end
  end

  assign lkup_ready_o       = r_lkup_ready;
  assign araddr_o           = r_araddr;
  assign arlen_o            = 8'd0;
  assign arvalid_o          = r_arvalid;
  assign rready_o           = r_rready;
  assign trnsl_valid_o      = r_tvalid;
  assign trnsl_ppa_o        = r_trnsl.ppa;
  assign trnsl_sts_o        = r_trnsl.sts;
  assign trnsl_zpd_cnt_o    = r_trnsl.zpd;
  assign trnsl_zpd_update_o = r_trnsl.upd;
  assign trnsl_allow_o      = r_trnsl.allow;
  assign trnsl_err_o        = r_trnsl.err;
  assign dbg_state_o        = r_state;

endmodule

// File: tb/tb_hawk_att_lkup_engine.sv
// Scoreboard bench for hawk_att_lkup_engine: directed lookups against a one-beat AXI slave model.
module tb_hawk_att_lkup_engine;
  localparam int PW = 28;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           rst_i;
  logic           lkup_valid_i, lkup_ready_o, lkup_zero_blk_wr_i, inval_i;
  logic [PW-1:0]  lkup_hppa_i;
  logic [63:0]    araddr_o;
  logic [7:0]     arlen_o;
  logic           arvalid_o, arready_i;
  logic [511:0]   rdata_i;
  logic [1:0]     rresp_i;
  logic           rvalid_i, rlast_i, rready_o;
  logic           trnsl_valid_o, trnsl_ready_i;
  logic [PW-1:0]  trnsl_ppa_o;
  logic [1:0]     trnsl_sts_o;
  logic [7:0]     trnsl_zpd_cnt_o;
  logic           trnsl_zpd_update_o, trnsl_allow_o, trnsl_err_o;
  logic [1:0]     dbg_state_o;
  logic           tb_inval_stim, tb_inval_slv;

  assign inval_i = tb_inval_stim | tb_inval_slv;

  hawk_att_lkup_engine dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lkup_valid_i(lkup_valid_i), .lkup_ready_o(lkup_ready_o),
    .lkup_hppa_i(lkup_hppa_i), .lkup_zero_blk_wr_i(lkup_zero_blk_wr_i),
    .inval_i(inval_i),
    .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rlast_i(rlast_i),
    .rready_o(rready_o),
    .trnsl_valid_o(trnsl_valid_o), .trnsl_ready_i(trnsl_ready_i),
    .trnsl_ppa_o(trnsl_ppa_o), .trnsl_sts_o(trnsl_sts_o), .trnsl_zpd_cnt_o(trnsl_zpd_cnt_o),
    .trnsl_zpd_update_o(trnsl_zpd_update_o), .trnsl_allow_o(trnsl_allow_o),
    .trnsl_err_o(trnsl_err_o), .dbg_state_o(dbg_state_o)
  );

  typedef struct packed {
    logic [PW-1:0] ppa;
    logic [1:0]    sts;
    logic [7:0]    zpd;
    logic          upd;
    logic          allow;
    logic          err;
  } exp_t;

  exp_t         sb_q[$];
  logic [63:0]  ar_q[$];
  int           checks = 0;
  int           failures = 0;
  int           ar_cnt = 0;
  int           ar_exp = 0;
  logic [511:0] mem_line;
  logic [1:0]   slv_resp;
  bit           slv_junk, slv_inval;

  localparam logic [63:0] E_UNC = 64'h0300000000ABCDE1;
  localparam logic [63:0] E_INC = 64'h7F00000012345673;
  localparam logic [63:0] E_CMP = 64'h0500000000FEDCB2;

  function automatic exp_t mk(input logic [PW-1:0] ppa, input logic [1:0] sts,
                              input logic [7:0] zpd, input logic upd,
                              input logic allow, input logic err);
    exp_t e;
    e.ppa = ppa; e.sts = sts; e.zpd = zpd; e.upd = upd; e.allow = allow; e.err = err;
    return e;
  endfunction

  function automatic exp_t cur_out();
    return mk(trnsl_ppa_o, trnsl_sts_o, trnsl_zpd_cnt_o, trnsl_zpd_update_o,
              trnsl_allow_o, trnsl_err_o);
  endfunction

  function automatic logic [511:0] line_prep(input logic [511:0] d);
    logic [511:0] o;
`ifdef HAWK_ATT_BYTESWAP_EN
    o = {512{1'b0}};
    for (int l = 0; l < 8; l++)
      for (int j = 0; j < 8; j++)
        o[64*l+8*j +: 8] = d[64*l+8*(7-j) +: 8];
`else
    o = d;
`endif
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic expect_ar(input logic [63:0] a);
    ar_q.push_back(a);
    ar_exp++;
  endtask

  // Response and AR monitors: pop the scoreboards whenever a handshake is pending.
  always @(negedge clk_i) begin
    if (!rst_i && trnsl_valid_o && trnsl_ready_i) begin
      if (sb_q.size() == 0) fail_now("unexpected_resp");
      else chk("resp", cur_out(), sb_q.pop_front());
    end
    if (!rst_i && arvalid_o && arready_i) begin
      ar_cnt++;
      chk("arlen", arlen_o, 8'd0);
      if (ar_q.size() == 0) fail_now("unexpected_ar");
      else chk("araddr", araddr_o, ar_q.pop_front());
    end
  end

  task automatic slv_beat();
    int n = 0;
    @(negedge clk_i);
    while (!rready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!rready_o) fail_now("rready_timeout");
    @(posedge clk_i); #1;
  endtask

  // AXI slave: one AR handshake, optional junk non-last beat, then the last beat.
  initial begin
    arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0;
    rdata_i = {512{1'b0}}; rresp_i = 2'b00; tb_inval_slv = 1'b0;
    forever begin
      @(negedge clk_i);
      if (arvalid_o && !rst_i) begin
        @(posedge clk_i); #1; arready_i = 1'b1;
        @(posedge clk_i); #1; arready_i = 1'b0;
        if (slv_junk) begin
          rvalid_i = 1'b1; rlast_i = 1'b0; rdata_i = ~mem_line; rresp_i = 2'b00;
          slv_beat();
        end
        rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = line_prep(mem_line);
        rresp_i = slv_resp; tb_inval_slv = slv_inval;
        slv_beat();
        rvalid_i = 1'b0; rlast_i = 1'b0; tb_inval_slv = 1'b0;
      end
    end
  end

  task automatic lookup(input logic [PW-1:0] hppa, input logic zbw,
                        input bit quick, input bit inval_acc);
    int n = 0;
    while (!lkup_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!lkup_ready_o) fail_now("ready_timeout");
    lkup_valid_i = 1'b1; lkup_hppa_i = hppa; lkup_zero_blk_wr_i = zbw;
    tb_inval_stim = inval_acc;
    @(posedge clk_i); #1;
    lkup_valid_i = 1'b0; tb_inval_stim = 1'b0;
    if (quick) begin
      chk("one_cycle_valid", trnsl_valid_o, 1'b1);
      chk("one_cycle_state", dbg_state_o, 2'd3);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || !lkup_ready_o) && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (sb_q.size() != 0 || !lkup_ready_o) fail_now({name, "_timeout"});
    chk({name, "_ar_count"}, ar_cnt, ar_exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; lkup_valid_i = 1'b0; lkup_hppa_i = {PW{1'b0}}; lkup_zero_blk_wr_i = 1'b0;
    tb_inval_stim = 1'b0; trnsl_ready_i = 1'b1;
    slv_resp = 2'b00; slv_junk = 1'b0; slv_inval = 1'b0;
    mem_line = {512{1'b0}};
    mem_line[63:0]    = 64'hFFFFFFFFFFFFFFFF;
    mem_line[191:128] = E_INC;
    mem_line[383:320] = E_UNC;
    mem_line[511:448] = E_CMP;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready_in_reset", lkup_ready_o, 1'b1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_ready", lkup_ready_o, 1'b1);
    chk("rst_ctrl", {trnsl_valid_o, arvalid_o, rready_o, dbg_state_o}, 5'b0);
    chk("rst_trnsl", cur_out(), mk(28'h0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    chk("rst_araddr", araddr_o, 64'd0);

    // Miss, UNCOMP, zero-block write, junk beat before the last one
    slv_junk = 1'b1;
    expect_ar(64'hFFF6100000);
    sb_q.push_back(mk(28'hABCDE, 2'd1, 8'd3, 1'b1, 1'b1, 1'b0));
    lookup(28'hFFF6405, 1'b1, 1'b0, 1'b0);
    wait_done("miss_unc");
    slv_junk = 1'b0;

    // Hit on the buffered line, INCOMP
    sb_q.push_back(mk(28'h1234567, 2'd3, 8'h7F, 1'b0, 1'b1, 1'b0));
    lookup(28'hFFF6402, 1'b1, 1'b1, 1'b0);
    wait_done("hit_inc");

    // Invalidate pulse forces a re-read
    @(posedge clk_i); #1; tb_inval_stim = 1'b1;
    @(posedge clk_i); #1; tb_inval_stim = 1'b0;
    expect_ar(64'hFFF6100000);
    sb_q.push_back(mk(28'h1234567, 2'd3, 8'h7F, 1'b0, 1'b1, 1'b0));
    lookup(28'hFFF6402, 1'b0, 1'b0, 1'b0);
    wait_done("inval_reread");

    // Out of range on both sides
    sb_q.push_back(mk(28'h0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1));
    lookup(28'hFFF6418, 1'b0, 1'b1, 1'b0);
    wait_done("oor_idx24");
    sb_q.push_back(mk(28'h0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1));
    lookup(28'hFFF63FF, 1'b1, 1'b1, 1'b0);
    wait_done("oor_below");

    // Last valid index: line 2, slot 7
    expect_ar(64'hFFF6100080);
    sb_q.push_back(mk(28'h00FEDCB, 2'd2, 8'd5, 1'b0, 1'b0, 1'b0));
    lookup(28'hFFF6417, 1'b0, 1'b0, 1'b0);
    wait_done("idx23");

    // AXI error, then the same line must be read again
    slv_resp = 2'b10;
    expect_ar(64'hFFF6100000);
    sb_q.push_back(mk(28'h0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1));
    lookup(28'hFFF6405, 1'b1, 1'b0, 1'b0);
    wait_done("axi_err");
    slv_resp = 2'b00;
    expect_ar(64'hFFF6100000);
    sb_q.push_back(mk(28'h0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    lookup(28'hFFF6404, 1'b1, 1'b0, 1'b0);
    wait_done("after_err_dalloc");

    // Zero-block write to COMP with the consumer stalled
    trnsl_ready_i = 1'b0;
    sb_q.push_back(mk(28'h00FEDCB, 2'd2, 8'd5, 1'b0, 1'b0, 1'b0));
    lookup(28'hFFF6407, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      chk("stall_outputs", cur_out(), mk(28'h00FEDCB, 2'd2, 8'd5, 1'b0, 1'b0, 1'b0));
      chk("stall_ready_valid", {lkup_ready_o, trnsl_valid_o}, 2'b01);
    end
    trnsl_ready_i = 1'b1;
    wait_done("stall_comp");

    // Invalidate at hit accept -> miss; invalidate at last beat -> buffer stays empty
    slv_inval = 1'b1;
    expect_ar(64'hFFF6100000);
    sb_q.push_back(mk(28'h1234567, 2'd3, 8'h7F, 1'b0, 1'b1, 1'b0));
    lookup(28'hFFF6402, 1'b0, 1'b0, 1'b1);
    wait_done("inval_at_accept");
    slv_inval = 1'b0;
    expect_ar(64'hFFF6100000);
    sb_q.push_back(mk(28'hABCDE, 2'd1, 8'd3, 1'b0, 1'b1, 1'b0));
    lookup(28'hFFF6405, 1'b0, 1'b0, 1'b0);
    wait_done("inval_at_last_beat");
    sb_q.push_back(mk(28'h0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    lookup(28'hFFF6404, 1'b1, 1'b1, 1'b0);
    wait_done("hit_dalloc");

    chk("sb_drained", sb_q.size(), 0);
    chk("ar_drained", ar_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hawk_att_lkup_engine.md
Name: hawk_att_lkup_engine

Overview:
- Translation stage directly downstream of the CPU-request front end and upstream of the translation override path.
- Accepts an ATT lookup request (hppa page number), fetches the 64 B ATT cache line over the AXI read master port and extracts the 8 B AttEntry.
- Produces a translation packet (ppa, sts, zpd_cnt, allow_access).
- Keeps a one-line ATT buffer so back-to-back lookups to the same line skip DRAM.

Parameters:
- ADDR_W, 40, AXI address width; hppa/ppa page fields are ADDR_W-12 bits.
- ATT_START, 64'hFFF6100000, byte base of the ATT table.
- HPPA_BASE, 64'hFFF6400000, byte base of the hawk physical page window.
- ATT_ENTRIES, 24, number of valid ATT entries; indices at or above this are out of range.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- lkup_valid_i  in  1  lookup request valid
- lkup_ready_o  out  1  lookup request accepted when both valid and ready are high
- lkup_hppa_i  in  ADDR_W-12  hppa page number
- lkup_zero_blk_wr_i  in  1  request is a zero-block write
- inval_i  in  1  ATT table was updated; drop the line buffer
- araddr_o  out  64  AXI read address
- arlen_o  out  8  AXI burst length, constant 0
- arvalid_o  out  1  AXI read address valid
- arready_i  in  1  AXI read address ready
- rdata_i  in  512  AXI read data
- rresp_i  in  2  AXI read response
- rvalid_i  in  1  AXI read data valid
- rlast_i  in  1  AXI read last beat
- rready_o  out  1  AXI read data ready
- trnsl_valid_o  out  1  translation valid
- trnsl_ready_i  in  1  translation consumer ready
- trnsl_ppa_o  out  ADDR_W-12  translated page number (AttEntry way[ADDR_W-11:2])
- trnsl_sts_o  out  2  AttEntry sts
- trnsl_zpd_cnt_o  out  8  AttEntry zpd_cnt
- trnsl_zpd_update_o  out  1  zero-block write to an uncompressed page
- trnsl_allow_o  out  1  access may proceed
- trnsl_err_o  out  1  out-of-range index or AXI error
- dbg_state_o  out  2  FSM state

Behaviour:
- Reset values:
  - FSM in IDLE.
  - lkup_ready_o=1; all other outputs 0.
  - Line buffer invalid; buffer tag 0.
- Index and address arithmetic:
  - idx = lkup_hppa_i − HPPA_BASE[ADDR_W-1:12], unsigned.
  - Line address = ATT_START + (idx>>3)*64.
  - Entry slice = line[64*idx[2:0] +: 64].
- Range check: if hppa < HPPA_BASE page or idx ≥ ATT_ENTRIES, the request is out of range.
  - No AXI traffic.
  - Response has err=1, allow=0, sts=STS_DALLOC, ppa=0, zpd_cnt=0.
- FSM states: IDLE, AR, R, RESP.
  - IDLE: lkup_ready_o=1. On accept:
    - Out-of-range → RESP next cycle.
    - Line buffer valid and tag == idx>>3 (hit) → RESP next cycle, one-cycle latency.
    - Otherwise → AR.
  - AR: arvalid_o=1 with a stable araddr_o; arlen_o=0. Go to R on arready_i.
  - R: rready_o=1. On rvalid_i & rlast_i:
    - Capture the line, then go to RESP.
    - If rresp_i==0: set buffer valid and tag.
    - If rresp_i!=0: err=1, allow=0, buffer invalid.
    - A non-last beat is a protocol violation; its data is ignored.
  - RESP: trnsl_valid_o=1; all trnsl_* outputs stay stable until trnsl_ready_i, then go to IDLE.
  - lkup_ready_o=0 in every state except IDLE.
- Decode of the entry:
  - allow = (sts==STS_UNCOMP) | (sts==STS_INCOMP).
  - zpd_update = lkup_zero_blk_wr_i (registered at accept) & sts==STS_UNCOMP.
  - DALLOC and COMP return allow=0, err=0.
- inval_i:
  - Clears buffer valid in any state.
  - Same cycle as a successful last beat: the data is still used for the current response, but the buffer stays invalid (inval_i wins).
  - Same cycle as a hit accept in IDLE: treated as a miss.
- Reset mid-operation: returns to the reset state immediately. An outstanding AXI read is abandoned; the interconnect is reset with the block.

Optional Feature:
- HAWK_ATT_BYTESWAP_EN defined: every captured line passes through an 8-byte byteswap before buffering and decode. Within each 64-bit lane, byte j takes byte 7−j. This matches big-endian table writes from the core.
- Not defined: rdata_i is buffered unmodified.

Test Plan:
- Miss, uncompressed, feature off:
  - Stimulus: hppa 0xFFF6405 (idx 5); line returns with [383:320]=0x03_00000000ABCDE_1 encoding (zpd_cnt 3, way 0xABCDE<<2, sts=01), rresp 0.
  - Required: araddr 0xFFF6100000, arlen 0.
  - Required response: ppa 0xABCDE, sts 1, zpd 3, allow 1, err 0.
- Hit after the miss above:
  - Stimulus: hppa 0xFFF6402 (idx 2), same line.
  - Required: no arvalid; trnsl_valid one cycle after accept; entry decoded from slice [191:128].
- inval_i pulsed, then hppa 0xFFF6402 again → new AXI read to 0xFFF6100000.
- Out of range:
  - Stimulus: hppa 0xFFF6418 (idx 24), then hppa 0xFFF63FF.
  - Required for each: no AXI read; err 1, allow 0, sts 0.
- AXI error: rresp=2'b10 → err 1, allow 0; the next lookup to the same line re-reads DRAM.
- Zero-block write to a COMP entry (sts 2):
  - Required: allow 0, zpd_update 0.
  - With trnsl_ready_i held low 5 cycles: outputs stay stable and lkup_ready_o stays low until the handshake.
